genius_autoplayer: RTL and testbench

GENIUS_AUTOPLAYER -- requirements
Module: genius_autoplayer

---
 rtl/genius_autoplayer.sv | 201 ++++++++++++++++++++
 tb/tb_genius_autoplayer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_autoplayer.sv
// Captures the game's LED sequence and replays it as registered button presses.
// Optional macro AUTOPLAYER_MISTAKE_EN; seq_len is one bit wider than the buffer index so that a full buffer can report DEPTH.
module genius_autoplayer #(
  parameter int DEPTH        = 16,
  parameter int PRESS_CYCLES = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [2:0]             leds_in,
  input  logic                   input_phase,
  output logic [2:0]             btn,
  output logic [$clog2(DEPTH):0] seq_len,
  output logic                   done,
  output logic                   error
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_PRESS   = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      leds_prev_q;
  logic            phase_prev_q;
  logic [LW-1:0]   seq_len_q, seq_len_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      btn_q, btn_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [1:0]      mem_wd;

  logic            cap_evt, phase_rise, leds_onehot, full, abort;
  logic [1:0]      leds_idx, press_idx;
  logic [LW-1:0]   ptr_inc, press_ptr;
  logic [2:0]      press_btn;

  assign cap_evt     = enable && !input_phase && (leds_prev_q == 3'b000) && (leds_in != 3'b000);
  assign phase_rise  = input_phase && !phase_prev_q;
  assign leds_onehot = (leds_in == 3'b001) || (leds_in == 3'b010) || (leds_in == 3'b100);
  assign full        = (seq_len_q == LW'(DEPTH));
  assign abort       = !enable || !input_phase;
  assign ptr_inc     = ptr_q + 1'b1;

  always_comb begin
    leds_idx = 2'd0;
    case (leds_in)
      3'b010:  leds_idx = 2'd1;
      3'b100:  leds_idx = 2'd2;
      default: leds_idx = 2'd0;
    endcase
  end

  // Entry that the next registered btn value will show, looked up one cycle ahead.
  always_comb begin
    press_ptr = '0;
    case (state_q)
      S_PRESS: press_ptr = ptr_q;
      S_GAP:   press_ptr = ptr_inc;
      default: press_ptr = '0;
    endcase
    press_idx = mem_q[press_ptr[AW-1:0]];
`ifdef AUTOPLAYER_MISTAKE_EN
    if (press_ptr == seq_len_q - LW'(1)) begin
      press_idx = (press_idx == 2'd2) ? 2'd0 : press_idx + 2'd1;
    end
`endif
    press_btn = 3'b001 << press_idx;
  end

  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    btn_d     = 3'b000;
    done_d    = 1'b0;
    error_d   = error_q;
    mem_we    = 1'b0;
    mem_wa    = seq_len_q[AW-1:0];
    mem_wd    = leds_idx;
    case (state_q)
      S_IDLE: begin
        if (cap_evt) begin
          if (!leds_onehot) begin
            error_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wa    = '0;
            seq_len_d = LW'(1);
            state_d   = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (!enable) begin
          state_d   = S_IDLE;
          seq_len_d = '0;
        end else if (phase_rise) begin
          state_d = S_PRESS;
          ptr_d   = '0;
          cnt_d   = '0;
          btn_d   = press_btn;
        end else if (cap_evt) begin
          if (!leds_onehot || full) begin
            error_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            seq_len_d = seq_len_q + LW'(1);
          end
        end
      end
      S_PRESS: begin
        if (abort) begin
          state_d   = S_IDLE;
          seq_len_d = '0;
        end else if (cnt_q == PRESS_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          btn_d = press_btn;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          seq_len_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          ptr_d = ptr_inc;
          cnt_d = '0;
          if (ptr_inc < seq_len_q) begin
            state_d = S_PRESS;
            btn_d   = press_btn;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        seq_len_d = '0;
      end
      default: begin
        state_d   = S_IDLE;
        seq_len_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      leds_prev_q  <= 3'b000;
      phase_prev_q <= 1'b0;
      seq_len_q    <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      btn_q        <= 3'b000;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      leds_prev_q  <= leds_in;
      phase_prev_q <= input_phase;
      seq_len_q    <= seq_len_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      btn_q        <= btn_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Buffer is never read beyond seq_len, so it carries no reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign btn     = btn_q;
  assign seq_len = seq_len_q;
  assign done    = done_q;
  assign error   = error_q;
endmodule

// File: tb/tb_genius_autoplayer.sv
// Randomized scoreboard bench for genius_autoplayer with a queue-based sequence model.
module tb_genius_autoplayer;
  localparam int DEPTH = 16;
  localparam int PC    = 2;
  localparam int GC    = 4;

  logic       clock = 1'b0;
  logic       reset, enable, input_phase;
  logic [2:0] leds_in;
  logic [2:0] btn;
  logic [4:0] seq_len;
  logic       done, error;

  always #5 clock = ~clock;

  genius_autoplayer #(.DEPTH(DEPTH), .PRESS_CYCLES(PC), .GAP_CYCLES(GC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .leds_in(leds_in),
    .input_phase(input_phase), .btn(btn), .seq_len(seq_len), .done(done), .error(error)
  );

  typedef struct {
    int         kind;  // 0 = press, 1 = done pulse
    logic [2:0] val;
    int         gap;   // -1: preceding gap not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   model_seq[$];
  bit   err_m;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  bit   mon_en = 1'b0;
  int   cur_len = 0;
  int   gap_cnt = 0;
  int   cur_gap = 0;
  logic [2:0] cur_val = 3'b000;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: measures each press (value, length, preceding gap) and done pulses.
  always @(negedge clock) begin
    if (done) done_seen++;
    if (!mon_en || reset) begin
      cur_len = 0;
      gap_cnt = 0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", 1, e.kind);
          chk("done_gap", gap_cnt, e.gap);
        end
        gap_cnt = 0;
      end
      if (btn != 3'b000) begin
        if (cur_len == 0) begin
          cur_val = btn;
          cur_gap = gap_cnt;
        end else if (btn != cur_val) chk("btn_stable", int'(btn), int'(cur_val));
        cur_len++;
      end else begin
        if (cur_len != 0) begin
          if (exp_q.size() == 0) chk("unexpected_press", int'(cur_val), 0);
          else begin
            e = exp_q.pop_front();
            chk("press_kind", 0, e.kind);
            chk("press_val", int'(cur_val), int'(e.val));
            chk("press_len", cur_len, PC);
            if (e.gap >= 0) chk("press_gap", cur_gap, e.gap);
          end
          cur_len = 0;
          gap_cnt = 0;
        end
        gap_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic bit is_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic int idx_of(input logic [2:0] v);
    return (v == 3'b001) ? 0 : (v == 3'b010) ? 1 : 2;
  endfunction

  task automatic show(input logic [2:0] v, input int lit, input int dark);
    leds_in = v;
    tick(lit);
    leds_in = 3'b000;
    tick(dark);
    if (enable && v != 3'b000) begin
      if (!is_onehot(v) || model_seq.size() == DEPTH) err_m = 1'b1;
      else model_seq.push_back(idx_of(v));
    end
  endtask

  task automatic replay(input string tag);
    int n, d0, budget, k;
    logic [2:0] first;
    exp_t x;
    n = model_seq.size();
    first = 3'b000;
    for (int i = 0; i < n; i++) begin
      k = model_seq[i];
`ifdef AUTOPLAYER_MISTAKE_EN
      if (i == n - 1) k = (k + 1) % 3;
`endif
      x.kind = 0;
      x.val  = 3'(1 << k);
      x.gap  = (i == 0) ? -1 : GC;
      if (i == 0) first = x.val;
      exp_q.push_back(x);
    end
    if (n > 0) begin
      x.kind = 1; x.val = 3'b000; x.gap = GC;
      exp_q.push_back(x);
    end
    d0 = done_seen;
    input_phase = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_first_press"}, int'(btn), int'(first));
    budget = n * (PC + GC) + 20;
    tick(1);
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    chk({tag, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    tick(PC + GC + 2);
    chk({tag, "_seq_len_after"}, int'(seq_len), 0);
    chk({tag, "_done_count"}, done_seen - d0, (n > 0) ? 1 : 0);
    chk({tag, "_error"}, int'(error), int'(err_m));
    input_phase = 1'b0;
    tick(2);
    model_seq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    err_m = 1'b0;
    model_seq.delete();
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, budget, n, r;
    logic [2:0] v;
    reset = 1'b1; enable = 1'b1; input_phase = 1'b0; leds_in = 3'b000; err_m = 1'b0;
    tick(2);
    chk("rst_btn", int'(btn), 0);
    chk("rst_seq_len", int'(seq_len), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;
    tick(2);
    mon_en = 1'b1;

    // Display 2, 0, 1 then replay.
    show(3'b100, 3, 2); show(3'b001, 3, 2); show(3'b010, 3, 2);
    chk("basic_seq_len", int'(seq_len), 3);
    replay("basic");

    // Non-one-hot display sets sticky error without storing.
    show(3'b001, 3, 2); show(3'b011, 1, 2);
    chk("multihot_error", int'(error), 1);
    chk("multihot_seq_len", int'(seq_len), model_seq.size());
    show(3'b010, 2, 2);
    replay("multihot");
    chk("error_sticky", int'(error), 1);
    do_reset();
    chk("error_cleared", int'(error), 0);

    // Overflow: 17 events into a 16-entry buffer.
    for (int i = 0; i < 17; i++) show(3'(1 << $urandom_range(0, 2)), 2, 1);
    chk("ovf_seq_len", int'(seq_len), DEPTH);
    chk("ovf_error", int'(error), 1);
    replay("ovf");

    // Disabled: nothing captured.
    enable = 1'b0;
    show(3'b001, 3, 2);
    chk("disabled_seq_len", int'(seq_len), 0);
    enable = 1'b1;

    // Abort by input_phase falling during the second press.
    mon_en = 1'b0;
    show(3'b001, 3, 2); show(3'b100, 3, 2); show(3'b010, 3, 2);
    input_phase = 1'b1;
    cnt = 0; budget = 100; v = 3'b000;
    while (cnt < 2 && budget > 0) begin
      @(negedge clock);
      if (btn != 3'b000 && v == 3'b000) cnt++;
      v = btn;
      budget--;
    end
    chk("abort_reached_press2", cnt, 2);
    chk("abort_press2_val", int'(btn), 4);
    n = done_seen;
    input_phase = 1'b0;
    @(negedge clock);
    chk("abort_btn", int'(btn), 0);
    chk("abort_seq_len", int'(seq_len), 0);
    tick(12);
    chk("abort_no_done", done_seen - n, 0);
    model_seq.delete();
    show(3'b100, 3, 2);
    chk("abort_idle_recapture", int'(seq_len), 1);
    mon_en = 1'b1;
    replay("post_abort");

    // Reset pulse mid-press clears outputs asynchronously.
    mon_en = 1'b0;
    show(3'b010, 3, 2); show(3'b001, 3, 2);
    input_phase = 1'b1;
    budget = 20;
    while (btn == 3'b000 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    chk("midreset_press_seen", int'(btn != 3'b000), 1);
    reset = 1'b1;
    #1;
    chk("midreset_btn", int'(btn), 0);
    chk("midreset_seq_len", int'(seq_len), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_error", int'(error), 0);
    tick(2);
    reset = 1'b0;
    input_phase = 1'b0;
    err_m = 1'b0;
    model_seq.delete();
    tick(2);
    mon_en = 1'b1;

    // Random rounds.
    for (int round = 0; round < 10; round++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) v = 3'($urandom_range(1, 7));
        else v = 3'(1 << $urandom_range(0, 2));
        show(v, $urandom_range(1, 4), $urandom_range(1, 3));
      end
      chk("rand_seq_len", int'(seq_len), model_seq.size());
      chk("rand_error", int'(error), int'(err_m));
      replay("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
